// File: rtl/operand_skewer_pkg.sv
// operand_skewer_pkg
//   Shared types and constants for the systolic-array feeder path.
//   - DEF_ARRAY_SIZE / DEF_DATA_WIDTH : default lane count and lane width
//   - precision_mode_t                : operand precision selector used downstream
//   - skew_state_t                    : operand_skewer stream FSM states
//   - cnt_width()                     : counter width able to hold values 0..n-1
package operand_skewer_pkg;

  localparam int DEF_ARRAY_SIZE = 4;
  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    PREC_INT8  = 2'd0,
    PREC_INT16 = 2'd1,
    PREC_FP16  = 2'd2
  } precision_mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } skew_state_t;

  // A 1-lane array still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/operand_skewer_skew_lane.sv
// skew_lane
//   DEPTH-stage, W-bit registered shift register with synchronous clear.
//   dout is din delayed by DEPTH clock edges.
//   Ports:
//     clk  - clock
//     rst  - asynchronous active-high reset, clears every stage
//     clr  - synchronous clear, wins over shifting
//     din  - value shifted into stage 0
//     dout - last stage
module skew_lane #(
  parameter int DEPTH = 1,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [DEPTH-1:0][W-1:0] stage_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_reg <= '0;
    end else if (clr) begin
      stage_reg <= '0;
    end else begin
      stage_reg[0] <= din;
      for (int k = 1; k < DEPTH; k++) begin
        stage_reg[k] <= stage_reg[k-1];
      end
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/operand_skewer.sv
// operand_skewer
//   Turns one unskewed beat (row of A + column of B) per handshake into the
//   diagonal wavefront the systolic array expects: lane i is delayed i+1
//   cycles. Generates first/last markers and a done pulse, and zero-flushes
//   the wavefront after the final beat.
//   Ports:
//     clk, rst                  - clock, asynchronous active-high reset
//     in_valid/in_ready/in_last - beat handshake and end-of-stream flag
//     in_a, in_b                - unskewed A / B lanes, lane i at [i*W +: W]
//     abort                     - synchronous stream kill, highest priority
//     input_data, weight_data   - skewed A / B to the array edges
//     input_first, weight_first - pulse when lane 0 shows the first beat
//     input_last, weight_last   - pulse when lane N-1 shows the final beat
//     busy                      - stream FSM not idle
//     done                      - pulse when final element enters lane N-1
module operand_skewer
  import operand_skewer_pkg::*;
#(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_last,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_a,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_b,
  input  logic                             abort,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] input_data,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] weight_data,
  output logic                             input_first,
  output logic                             weight_first,
  output logic                             input_last,
  output logic                             weight_last,
  output logic                             busy,
  output logic                             done
);

  localparam int CNT_W = cnt_width(ARRAY_SIZE);
  // The flush lasts N cycles after the last accept: counter N-1 down to 0.
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(ARRAY_SIZE - 1);

  skew_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             accept;
  logic             first_in;
  logic             last_in;
  logic             first_q;
  logic             last_q;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (abort) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (in_last) begin
              state_next = FLUSH;
              cnt_next   = FLUSH_LOAD;
            end else begin
              state_next = STREAM;
            end
          end
        end
        STREAM: begin
          if (accept && in_last) begin
            state_next = FLUSH;
            cnt_next   = FLUSH_LOAD;
          end
        end
        FLUSH: begin
          if (cnt_reg == '0) begin
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    in_ready = (state_reg != FLUSH) && !abort;
    busy     = (state_reg != IDLE);
    // An abort landing on the final flush cycle kills the done pulse too.
    done     = (state_reg == FLUSH) && (cnt_reg == '0) && !abort;
    accept   = in_valid && in_ready;
    // Only an accept from IDLE starts a stream; STREAM accepts are middles.
    first_in = accept && (state_reg == IDLE);
    last_in  = accept && in_last;
  end

  // ---------------------------------------------------------------------
  // Data skew lines: lane gi of A and B delayed gi+1 cycles. Non-accepted
  // cycles feed zeros so bubbles and the flush appear as zero diagonals.
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] a_din;
      logic [DATA_WIDTH-1:0] b_din;

      assign a_din = accept ? in_a[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
      assign b_din = accept ? in_b[gi*DATA_WIDTH +: DATA_WIDTH] : '0;

      skew_lane #(.DEPTH(gi + 1), .W(DATA_WIDTH)) u_lane_a (
        .clk  (clk),
        .rst  (rst),
        .clr  (abort),
        .din  (a_din),
        .dout (input_data[gi*DATA_WIDTH +: DATA_WIDTH])
      );

      skew_lane #(.DEPTH(gi + 1), .W(DATA_WIDTH)) u_lane_b (
        .clk  (clk),
        .rst  (rst),
        .clr  (abort),
        .din  (b_din),
        .dout (weight_data[gi*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Marker pipes: first tracks lane 0, last tracks lane N-1. A and B
  // markers share identical timing, so one pipe drives both.
  // ---------------------------------------------------------------------
  skew_lane #(.DEPTH(1), .W(1)) u_first_pipe (
    .clk  (clk),
    .rst  (rst),
    .clr  (abort),
    .din  (first_in),
    .dout (first_q)
  );

  skew_lane #(.DEPTH(ARRAY_SIZE), .W(1)) u_last_pipe (
    .clk  (clk),
    .rst  (rst),
    .clr  (abort),
    .din  (last_in),
    .dout (last_q)
  );

  assign input_first  = first_q;
  assign weight_first = first_q;
  assign input_last   = last_q;
  assign weight_last  = last_q;

endmodule
